pic_interrupt_sequencer: RTL and testbench
==========================================

Name: pic_interrupt_sequencer

Overview:
Clocked interrupt-resolution core for the 8259A PIC. It holds IRR and ISR and resolves priority against the OCW1 mask. It runs the two-pulse INTA acknowledge sequence and executes OCW2 EOI and rotation commands. It consumes the command words latched by the bus-interface block and drives INT and the acknowledge vector toward the data-bus buffer.

Parameters:
NUM_IR, 8, number of interrupt inputs; only 8 is supported, and it sizes IRR, ISR and the mask.
SPURIOUS_IR, 7, IR index returned when INTA arrives with nothing pending.

Ports:
clk  in  1  single system clock; all state changes on the rising edge.
reset  in  1  synchronous, active-high reset.
init_pulse  in  1  one-cycle pulse on an ICW1 write; re-initialises like reset.
ir_in  in  8  IR0..IR7 request lines, already synchronised to clk.
level_mode  in  1  ICW1[3] LTIM; 1 = level-triggered, 0 = edge-triggered.
vector_base  in  5  ICW2[7:3].
aeoi  in  1  ICW4[1] automatic EOI.
imr  in  8  OCW1 mask; 1 = masked.
ocw2  in  8  OCW2 value.
ocw2_valid  in  1  one-cycle pulse when OCW2 is written.
inta_pulse  in  1  one-cycle pulse per INTA falling edge, already synchronised.
int_out  out  1  INT request to the CPU.
vector_out  out  8  acknowledge vector.
vector_valid  out  1  one-cycle strobe; vector_out is valid this cycle.
irr  out  8  interrupt request register, for status reads.
isr  out  8  in-service register, for status reads.

Behaviour:
- Reset and init_pulse behave identically:
  - irr, isr, int_out, vector_out, vector_valid = 0.
  - Lowest-priority register lp = 7, so IR0 is highest.
  - rotate_aeoi = 0, FSM = IDLE, ir_prev = 0.
- Clock and reset: one clock; reset is synchronous and active-high.
- IRR capture:
  - Edge mode sets irr[i] when ir_in[i] & ~ir_prev[i].
  - Level mode sets irr[i] while ir_in[i] = 1.
  - In both modes, irr[i] clears when ir_in[i] = 0.
  - The ACK1 clear (below) takes precedence over a same-cycle set of the same bit.
- Priority:
  - Ranking order is lp+1, lp+2, …, lp (mod 8).
  - pending = irr & ~imr.
  - int_out is registered: high one cycle after pending holds a bit ranked strictly higher than the highest set isr bit (or any bit when isr = 0).
  - int_out is forced low in ACK2.
- FSM states are IDLE, ACK2.
  - IDLE, inta_pulse: latch winner = highest-ranked pending bit, set isr[winner], clear irr[winner], go to ACK2.
  - If nothing is pending at that point: winner = SPURIOUS_IR, isr and irr unchanged, spurious flag set.
  - ACK2, inta_pulse: vector_out = {vector_base, winner[2:0]} and vector_valid = 1 for exactly one cycle, then IDLE.
  - If aeoi = 1 and the acknowledge was not spurious: clear isr[winner] in that same cycle. If rotate_aeoi = 1, also set lp = winner.
  - inta_pulse in ACK2 is the only exit from ACK2; there is no timeout.
- Latency:
  - vector_valid is asserted the cycle after the second inta_pulse.
  - isr update is visible the cycle after the first inta_pulse.
- OCW2 decode uses R,SL,EOI = ocw2[7:5] and L = ocw2[2:0]:
  - 001: non-specific EOI; clear the highest-ranked isr bit.
  - 011: specific EOI; clear isr[L].
  - 101: rotate on non-specific EOI; clear the highest-ranked isr bit and set lp to its index.
  - 111: rotate on specific EOI; clear isr[L] and set lp = L.
  - 100: rotate_aeoi = 1.
  - 000: rotate_aeoi = 0.
  - 110: set priority; lp = L.
  - 010: no-op.
  - Any EOI with isr = 0 is a no-op, including the rotate.
- Simultaneous OCW2 EOI and ACK1 isr set: the EOI clear is computed on the old isr, then the set is applied; set wins on the same bit.
- init_pulse in mid-sequence aborts to IDLE; no vector_valid is emitted.

Decomposition:
- Shared package pic_pkg holds:
  - OCW2 command encodings.
  - FSM state typedef.
  - Constants SPURIOUS_IR, IR_WIDTH = 3.
- One natural sub-module, pic_priority_resolver (combinational). Inputs: 8-bit request, 8-bit isr, lp. Outputs: winner index, valid flag, "higher than in-service" flag. It is used for both the interrupt decision and the non-specific EOI target.

Test Plan:
1. Reset, ir_in = 0x04 edge, imr = 0, vector_base = 0x08 → int_out = 1; two INTA pulses → isr = 0x04 after the first, vector_out = 0x0A with one-cycle vector_valid after the second.
2. IR2 in service, raise IR5 → int_out stays 0; raise IR1 → int_out = 1 (nesting); non-specific EOI → isr clears bit 1 first.
3. OCW2 = 0xC3 (set priority, L = 3), then IR3 and IR4 pending → IR4 acknowledged first (vector base+4).
4. aeoi = 1, rotate_aeoi via OCW2 = 0x80, acknowledge IR6 → isr = 0 after the second INTA, lp = 6, so IR7 now ranks highest.
5. Level mode: IR0 pulse drops before the first INTA → spurious; vector = base+7, isr stays 0.
6. init_pulse between the two INTA pulses → FSM IDLE, isr = 0, no vector_valid; a same-cycle specific EOI and ACK1 on the same bit → bit set.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared definitions for the 8259A interrupt sequencer: OCW2 command codes,
// FSM state type and the rank-order priority-encoder helper.
package pic_pkg;

  localparam int          IR_WIDTH    = 3;
  localparam logic [2:0]  SPURIOUS_IR = 3'd7;

  // OCW2 {R, SL, EOI} command field
  localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
  localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
  localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK2 = 1'b1
  } state_t;

  // Returns {any, rank} where rank is the lowest set bit position.
  function automatic logic [IR_WIDTH:0] first_set(input logic [7:0] v);
    logic [IR_WIDTH:0] res;
    res = '0;
    for (int k = 7; k >= 0; k--) begin
      if (v[k]) res = {1'b1, 3'(k)};
    end
    return res;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Combinational rotating-priority resolver: picks the highest-ranked request
// and reports whether it outranks the highest in-service bit.
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [7:0]          request,
  input  logic [7:0]          in_service,
  input  logic [IR_WIDTH-1:0] lp,
  output logic [IR_WIDTH-1:0] winner,
  output logic                valid,
  output logic                higher
);

  // Rotate so that rank 0 is the IR just above the lowest-priority one.
  logic [7:0] req_rot;
  logic [7:0] isr_rot;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_rot
      logic [IR_WIDTH-1:0] src;
      assign src         = lp + 3'(gi + 1);
      assign req_rot[gi] = request[src];
      assign isr_rot[gi] = in_service[src];
    end
  endgenerate

  logic [IR_WIDTH:0] req_first;
  logic [IR_WIDTH:0] isr_first;

  always_comb begin
    req_first = first_set(req_rot);
    isr_first = first_set(isr_rot);
    valid     = req_first[IR_WIDTH];
    winner    = lp + req_first[IR_WIDTH-1:0] + 3'd1;
    higher    = req_first[IR_WIDTH] &&
                (!isr_first[IR_WIDTH] ||
                 (req_first[IR_WIDTH-1:0] < isr_first[IR_WIDTH-1:0]));
  end

endmodule

// File: rtl/pic_interrupt_sequencer.sv
// 8259A interrupt-resolution core: IRR/ISR tracking, priority against the mask,
// two-pulse INTA acknowledge and OCW2 EOI/rotation handling.
module pic_interrupt_sequencer #(
  parameter int         NUM_IR      = 8,
  parameter logic [2:0] SPURIOUS_IR = 3'd7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_pulse,
  input  logic [NUM_IR-1:0] ir_in,
  input  logic              level_mode,
  input  logic [4:0]        vector_base,
  input  logic              aeoi,
  input  logic [NUM_IR-1:0] imr,
  input  logic [7:0]        ocw2,
  input  logic              ocw2_valid,
  input  logic              inta_pulse,
  output logic              int_out,
  output logic [7:0]        vector_out,
  output logic              vector_valid,
  output logic [NUM_IR-1:0] irr,
  output logic [NUM_IR-1:0] isr
);

  import pic_pkg::*;

  state_t              state_reg, state_next;
  logic [7:0]          irr_reg, irr_next;
  logic [7:0]          isr_reg, isr_next;
  logic [7:0]          ir_prev_reg;
  logic [IR_WIDTH-1:0] lp_reg, lp_next;
  logic                rotate_aeoi_reg, rotate_aeoi_next;
  logic [IR_WIDTH-1:0] winner_reg, winner_next;
  logic                spurious_reg, spurious_next;
  logic                int_reg, int_next;
  logic [7:0]          vector_out_reg, vector_out_next;
  logic                vector_valid_reg, vector_valid_next;

  logic [7:0]          pending;
  logic [IR_WIDTH-1:0] pend_winner, eoi_target;
  logic                pend_valid, pend_higher;
  logic                eoi_valid, eoi_higher_unused;
  logic [7:0]          irr_set, irr_clr, isr_set, isr_clr;
  logic [IR_WIDTH-1:0] ocw2_level;

  assign pending    = irr_reg & ~imr;
  assign ocw2_level = ocw2[2:0];

  pic_priority_resolver u_int_resolver (
    .request    (pending),
    .in_service (isr_reg),
    .lp         (lp_reg),
    .winner     (pend_winner),
    .valid      (pend_valid),
    .higher     (pend_higher)
  );

  pic_priority_resolver u_eoi_resolver (
    .request    (isr_reg),
    .in_service (8'h00),
    .lp         (lp_reg),
    .winner     (eoi_target),
    .valid      (eoi_valid),
    .higher     (eoi_higher_unused)
  );

  always_comb begin
    state_next        = state_reg;
    lp_next           = lp_reg;
    rotate_aeoi_next  = rotate_aeoi_reg;
    winner_next       = winner_reg;
    spurious_next     = spurious_reg;
    vector_out_next   = vector_out_reg;
    vector_valid_next = 1'b0;
    irr_set           = level_mode ? ir_in : (ir_in & ~ir_prev_reg);
    irr_clr           = '0;
    isr_set           = '0;
    isr_clr           = '0;

    // EOI clears are computed on the current isr; an ACK1 set below still wins.
    if (ocw2_valid) begin
      case (ocw2[7:5])
        OCW2_NS_EOI:       if (eoi_valid) isr_clr[eoi_target] = 1'b1;
        OCW2_SP_EOI:       if (eoi_valid) isr_clr[ocw2_level] = 1'b1;
        OCW2_ROT_NS_EOI: begin
          if (eoi_valid) begin
            isr_clr[eoi_target] = 1'b1;
            lp_next             = eoi_target;
          end
        end
        OCW2_ROT_SP_EOI: begin
          if (eoi_valid) begin
            isr_clr[ocw2_level] = 1'b1;
            lp_next             = ocw2_level;
          end
        end
        OCW2_ROT_AEOI_SET: rotate_aeoi_next = 1'b1;
        OCW2_ROT_AEOI_CLR: rotate_aeoi_next = 1'b0;
        OCW2_SET_PRIO:     lp_next = ocw2_level;
        default:           ;
      endcase
    end

    case (state_reg)
      ST_IDLE: begin
        if (inta_pulse) begin
          state_next = ST_ACK2;
          if (pend_valid) begin
            winner_next          = pend_winner;
            spurious_next        = 1'b0;
            isr_set[pend_winner] = 1'b1;
            irr_clr[pend_winner] = 1'b1;
          end else begin
            winner_next   = SPURIOUS_IR;
            spurious_next = 1'b1;
          end
        end
      end
      ST_ACK2: begin
        if (inta_pulse) begin
          state_next        = ST_IDLE;
          vector_valid_next = 1'b1;
          vector_out_next   = {vector_base, winner_reg};
          if (aeoi && !spurious_reg) begin
            isr_clr[winner_reg] = 1'b1;
            if (rotate_aeoi_reg) lp_next = winner_reg;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    irr_next = ((irr_reg | irr_set) & ir_in) & ~irr_clr;
    isr_next = (isr_reg & ~isr_clr) | isr_set;
    int_next = pend_higher && (state_next == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset || init_pulse) begin
      state_reg        <= ST_IDLE;
      irr_reg          <= '0;
      isr_reg          <= '0;
      ir_prev_reg      <= '0;
      lp_reg           <= 3'd7;
      rotate_aeoi_reg  <= 1'b0;
      winner_reg       <= '0;
      spurious_reg     <= 1'b0;
      int_reg          <= 1'b0;
      vector_out_reg   <= '0;
      vector_valid_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      irr_reg          <= irr_next;
      isr_reg          <= isr_next;
      ir_prev_reg      <= ir_in;
      lp_reg           <= lp_next;
      rotate_aeoi_reg  <= rotate_aeoi_next;
      winner_reg       <= winner_next;
      spurious_reg     <= spurious_next;
      int_reg          <= int_next;
      vector_out_reg   <= vector_out_next;
      vector_valid_reg <= vector_valid_next;
    end
  end

  assign int_out      = int_reg;
  assign vector_out   = vector_out_reg;
  assign vector_valid = vector_valid_reg;
  assign irr          = irr_reg;
  assign isr          = isr_reg;

endmodule

// File: tb/tb_pic_interrupt_sequencer.sv
// Directed bench: expected vectors are queued at stimulus time and a monitor
// pops and compares them on every vector_valid strobe.
module tb_pic_interrupt_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init_pulse = 1'b0;
  logic [7:0] ir_in = 8'h00;
  logic       level_mode = 1'b0;
  logic [4:0] vector_base = 5'h01;
  logic       aeoi = 1'b0;
  logic [7:0] imr = 8'h00;
  logic [7:0] ocw2 = 8'h00;
  logic       ocw2_valid = 1'b0;
  logic       inta_pulse = 1'b0;
  logic       int_out;
  logic [7:0] vector_out;
  logic       vector_valid;
  logic [7:0] irr;
  logic [7:0] isr;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  pic_interrupt_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .init_pulse   (init_pulse),
    .ir_in        (ir_in),
    .level_mode   (level_mode),
    .vector_base  (vector_base),
    .aeoi         (aeoi),
    .imr          (imr),
    .ocw2         (ocw2),
    .ocw2_valid   (ocw2_valid),
    .inta_pulse   (inta_pulse),
    .int_out      (int_out),
    .vector_out   (vector_out),
    .vector_valid (vector_valid),
    .irr          (irr),
    .isr          (isr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%02h want=%02h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s = %02h", name, act);
    end
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && vector_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_vector got=%02h want=none at %0t", vector_out, $time);
      end else begin
        check("vector", vector_out, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic inta();
    inta_pulse = 1'b1;
    tick();
    inta_pulse = 1'b0;
  endtask

  task automatic do_ocw2(input logic [7:0] v);
    ocw2       = v;
    ocw2_valid = 1'b1;
    tick();
    ocw2_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "time limit");
  end

  initial begin
    tick(); tick();
    reset = 1'b0;
    check("rst_irr", irr, 8'h00);
    check("rst_isr", isr, 8'h00);
    check("rst_int", {7'd0, int_out}, 8'h00);
    check("rst_vv", {7'd0, vector_valid}, 8'h00);

    // 1: single edge request on IR2, base 0x08
    ir_in = 8'h04; tick(); tick();
    check("t1_int", {7'd0, int_out}, 8'h01);
    exp_q.push_back(8'h0A);
    inta();
    check("t1_isr_ack1", isr, 8'h04);
    check("t1_irr_ack1", irr, 8'h00);
    check("t1_int_ack2", {7'd0, int_out}, 8'h00);
    inta();
    tick();
    check("t1_vv_oneshot", {7'd0, vector_valid}, 8'h00);

    // 2: nesting under IR2 in service
    ir_in = 8'h20; tick(); tick();
    check("t2_int_lower", {7'd0, int_out}, 8'h00);
    ir_in = 8'h22; tick(); tick();
    check("t2_int_higher", {7'd0, int_out}, 8'h01);
    exp_q.push_back(8'h09);
    inta();
    check("t2_isr_nest", isr, 8'h06);
    inta();
    do_ocw2(8'h20);
    check("t2_ns_eoi1", isr, 8'h04);
    do_ocw2(8'h20);
    check("t2_ns_eoi2", isr, 8'h00);
    tick();
    check("t2_int_ir5", {7'd0, int_out}, 8'h01);
    exp_q.push_back(8'h0D);
    inta(); inta();
    do_ocw2(8'h20);
    ir_in = 8'h00; tick();
    check("t2_isr_clean", isr, 8'h00);

    // 3: set priority lp=3, IR4 outranks IR3
    do_ocw2(8'hC3);
    ir_in = 8'h18; tick(); tick();
    exp_q.push_back(8'h0C);
    inta(); inta();
    check("t3_isr_ir4", isr, 8'h10);
    do_ocw2(8'h64);
    check("t3_sp_eoi", isr, 8'h00);
    tick();
    exp_q.push_back(8'h0B);
    inta(); inta();
    check("t3_isr_ir3", isr, 8'h08);
    do_ocw2(8'h20);
    do_ocw2(8'hC7);
    ir_in = 8'h00; tick();

    // 4: auto EOI with rotation
    aeoi = 1'b1;
    do_ocw2(8'h80);
    ir_in = 8'h40; tick(); tick();
    exp_q.push_back(8'h0E);
    inta();
    check("t4_isr_ack1", isr, 8'h40);
    inta();
    check("t4_isr_aeoi", isr, 8'h00);
    ir_in = 8'h00; tick();
    ir_in = 8'hA0; tick(); tick();
    exp_q.push_back(8'h0F);
    inta(); inta();
    check("t4_isr_ir7", isr, 8'h00);
    check("t4_irr_ir5", irr, 8'h20);
    tick();
    exp_q.push_back(8'h0D);
    inta(); inta();
    do_ocw2(8'h00);
    aeoi = 1'b0;
    do_ocw2(8'hC7);
    ir_in = 8'h00; tick();

    // 5: level mode, request drops before INTA -> spurious
    level_mode = 1'b1;
    ir_in = 8'h01; tick();
    check("t5_irr_level", irr, 8'h01);
    tick();
    check("t5_int", {7'd0, int_out}, 8'h01);
    ir_in = 8'h00; tick();
    check("t5_irr_drop", irr, 8'h00);
    exp_q.push_back(8'h0F);
    inta();
    check("t5_isr_spur1", isr, 8'h00);
    inta();
    check("t5_isr_spur2", isr, 8'h00);
    level_mode = 1'b0;

    // 6: init between INTA pulses, then EOI vs ACK1 on the same bit
    ir_in = 8'h08; tick(); tick();
    inta();
    check("t6_isr_ack1", isr, 8'h08);
    init_pulse = 1'b1; ir_in = 8'h00; tick();
    init_pulse = 1'b0;
    check("t6_init_isr", isr, 8'h00);
    check("t6_init_irr", irr, 8'h00);
    check("t6_init_int", {7'd0, int_out}, 8'h00);
    tick(); tick(); tick();
    ir_in = 8'h08; tick(); tick();
    exp_q.push_back(8'h0B);
    inta(); inta();
    check("t6_isr_again", isr, 8'h08);
    ir_in = 8'h00; tick();
    ir_in = 8'h08; tick();
    check("t6_irr_reraise", irr, 8'h08);
    ocw2 = 8'h63; ocw2_valid = 1'b1; inta_pulse = 1'b1;
    tick();
    ocw2_valid = 1'b0; inta_pulse = 1'b0;
    check("t6_set_wins", isr, 8'h08);
    check("t6_irr_cleared", irr, 8'h00);
    exp_q.push_back(8'h0B);
    inta();
    tick(); tick();
    check("queue_drained", 8'(exp_q.size()), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
